// File: rtl/v_counter_pkg.sv
// Shared constants and bound handling for the signed counter family.
package v_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Wide enough for WIDTH + STEP_W + 1 intermediate sums of any practical counter.
  localparam int unsigned CALC_W = 48;

  typedef logic signed [CALC_W-1:0] calc_t;

  // Fold an out-of-range value back into [min_v, max_v]; valid while |overshoot| <= range.
  function automatic calc_t bound_adjust(calc_t nxt, calc_t min_v, calc_t max_v, logic sat);
    calc_t r;
    r = nxt;
    if (nxt > max_v) begin
      r = sat ? max_v : nxt - (max_v - min_v + CALC_W'(1));
    end else if (nxt < min_v) begin
      r = sat ? min_v : nxt + (max_v - min_v + CALC_W'(1));
    end
    return r;
  endfunction

endpackage

// File: rtl/v_counter_bound.sv
// Combinational next-count and bound-crossing detection for the up/down counter.
module v_counter_bound
  import v_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter int          MAX_VAL  = 2**(WIDTH-1) - 1,
  parameter int          MIN_VAL  = -(2**(WIDTH-1)),
  parameter int unsigned STEP_W   = 4
) (
  input  logic signed [WIDTH-1:0]  i_q,
  input  logic                     i_up,
  input  logic        [STEP_W-1:0] i_step,
  output logic signed [WIDTH-1:0]  o_next_q_c,
  output logic                     o_crossed_c
);

  localparam int unsigned EW    = WIDTH + STEP_W + 1;
  localparam calc_t       MAX_C = CALC_W'(MAX_VAL);
  localparam calc_t       MIN_C = CALC_W'(MIN_VAL);
  localparam bit          SAT   = (SATURATE == MODE_SAT);

  logic signed [EW-1:0] w_q_ext;
  logic signed [EW-1:0] w_step_ext;
  logic signed [EW-1:0] w_nxt;
  calc_t                w_nxt_c;

  // Sum is wide enough that Q +/- STEP never overflows before the bound check.
  assign w_q_ext    = EW'(i_q);
  assign w_step_ext = EW'(i_step);
  assign w_nxt      = i_up ? (w_q_ext + w_step_ext) : (w_q_ext - w_step_ext);
  assign w_nxt_c    = CALC_W'(w_nxt);

  assign o_crossed_c = (w_nxt_c > MAX_C) || (w_nxt_c < MIN_C);
  assign o_next_q_c  = WIDTH'(bound_adjust(w_nxt_c, MIN_C, MAX_C, SAT));

endmodule

// File: rtl/v_counter_updown_param.sv
// Parametrised signed up/down counter: async clear, sync load, enable, wrap or saturate.
module v_counter_updown_param
  import v_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter int          MAX_VAL  = 2**(WIDTH-1) - 1,
  parameter int          MIN_VAL  = -(2**(WIDTH-1)),
  parameter int unsigned STEP_W   = 4
) (
  input  logic                     C,
  input  logic                     CLR,
  input  logic                     CE,
  input  logic                     LOAD,
  input  logic signed [WIDTH-1:0]  D,
  input  logic                     UP,
  input  logic        [STEP_W-1:0] STEP,
  output logic signed [WIDTH-1:0]  Q,
  output logic                     TC_MAX,
  output logic                     TC_MIN,
  output logic                     WRAP
);

  localparam calc_t                   MAX_C      = CALC_W'(MAX_VAL);
  localparam calc_t                   MIN_C      = CALC_W'(MIN_VAL);
  localparam calc_t                   RANGE_C    = MAX_C - MIN_C + CALC_W'(1);
  localparam logic signed [WIDTH-1:0] MAX_Q      = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH-1:0] MIN_Q      = WIDTH'(MIN_VAL);
  localparam bit                      TC_MAX_RST = (MAX_VAL == 0);
  localparam bit                      TC_MIN_RST = (MIN_VAL == 0);

  logic signed [WIDTH-1:0] r_q;
  logic                    r_tc_max;
  logic                    r_tc_min;
  logic                    r_wrap;
  logic signed [WIDTH-1:0] w_cnt_q;
  logic                    w_crossed;
  logic signed [WIDTH-1:0] w_q_next;
  logic                    w_wrap_next;

  v_counter_bound #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE),
    .MAX_VAL  (MAX_VAL),
    .MIN_VAL  (MIN_VAL),
    .STEP_W   (STEP_W)
  ) u_bound (
    .i_q         (r_q),
    .i_up        (UP),
    .i_step      (STEP),
    .o_next_q_c  (w_cnt_q),
    .o_crossed_c (w_crossed)
  );

  // Load takes priority over counting; loaded values are clamped into range.
  always_comb begin
    w_q_next    = w_cnt_q;
    w_wrap_next = w_crossed;
    if (LOAD) begin
      w_q_next    = WIDTH'(bound_adjust(calc_t'(D), MIN_C, MAX_C, 1'b1));
      w_wrap_next = 1'b0;
    end
  end

  // Flags are computed from the next value so they line up with Q.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_q      <= '0;
      r_tc_max <= TC_MAX_RST;
      r_tc_min <= TC_MIN_RST;
      r_wrap   <= 1'b0;
    end else if (CE) begin
      r_q      <= w_q_next;
      r_tc_max <= (w_q_next == MAX_Q);
      r_tc_min <= (w_q_next == MIN_Q);
      r_wrap   <= w_wrap_next;
    end else begin
      r_wrap   <= 1'b0;
    end
  end

  // A single conditional add/subtract only folds steps no larger than the range.
  always_ff @(posedge C) begin
    if (!CLR && CE && !LOAD) begin
      assert (calc_t'(STEP) <= RANGE_C);
    end
  end

  assign Q      = r_q;
  assign TC_MAX = r_tc_max;
  assign TC_MIN = r_tc_min;
  assign WRAP   = r_wrap;

endmodule

// File: tb/tb_v_counter_updown_param.sv
// Eight counter configurations driven in lockstep and checked against an arithmetic model.
module tb_v_counter_updown_param;

  localparam int NI = 8;
  localparam int CW    [NI] = '{4, 8, 3, 3, 8, 8, 16, 16};
  localparam int CMAX  [NI] = '{7, 5, 3, 3, 127, 127, 32767, 32767};
  localparam int CMIN  [NI] = '{-8, -3, -4, -4, -128, -128, -32768, -32768};
  localparam int CSAT  [NI] = '{0, 1, 0, 1, 0, 1, 0, 1};
  localparam int USE_N [NI] = '{0, 1, 1, 1, 0, 0, 0, 0};

  logic        clk = 1'b0;
  logic        clr, ce, load, up;
  logic [15:0] d16;
  logic [3:0]  step_w, step_n;

  logic signed [3:0]  q0;
  logic signed [7:0]  q1, q4, q5;
  logic signed [2:0]  q2, q3;
  logic signed [15:0] q6, q7;
  logic [NI-1:0] obs_tmax, obs_tmin, obs_wrap;
  int obs_q [NI];

  int mq [NI];
  int mw [NI];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Narrow-range instances get a step folded into 0..8 so it never exceeds their range.
  assign step_n = (step_w > 4'd8) ? (step_w - 4'd8) : step_w;

  v_counter_updown_param #(.WIDTH(4)) u0 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load), .D(d16[3:0]),
    .UP(up), .STEP(step_w), .Q(q0), .TC_MAX(obs_tmax[0]), .TC_MIN(obs_tmin[0]), .WRAP(obs_wrap[0]));
  v_counter_updown_param #(.WIDTH(8), .SATURATE(1), .MAX_VAL(5), .MIN_VAL(-3)) u1 (.C(clk), .CLR(clr),
    .CE(ce), .LOAD(load), .D(d16[7:0]), .UP(up), .STEP(step_n), .Q(q1), .TC_MAX(obs_tmax[1]),
    .TC_MIN(obs_tmin[1]), .WRAP(obs_wrap[1]));
  v_counter_updown_param #(.WIDTH(3)) u2 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load), .D(d16[2:0]),
    .UP(up), .STEP(step_n), .Q(q2), .TC_MAX(obs_tmax[2]), .TC_MIN(obs_tmin[2]), .WRAP(obs_wrap[2]));
  v_counter_updown_param #(.WIDTH(3), .SATURATE(1)) u3 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load),
    .D(d16[2:0]), .UP(up), .STEP(step_n), .Q(q3), .TC_MAX(obs_tmax[3]), .TC_MIN(obs_tmin[3]),
    .WRAP(obs_wrap[3]));
  v_counter_updown_param #(.WIDTH(8)) u4 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load), .D(d16[7:0]),
    .UP(up), .STEP(step_w), .Q(q4), .TC_MAX(obs_tmax[4]), .TC_MIN(obs_tmin[4]), .WRAP(obs_wrap[4]));
  v_counter_updown_param #(.WIDTH(8), .SATURATE(1)) u5 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load),
    .D(d16[7:0]), .UP(up), .STEP(step_w), .Q(q5), .TC_MAX(obs_tmax[5]), .TC_MIN(obs_tmin[5]),
    .WRAP(obs_wrap[5]));
  v_counter_updown_param #(.WIDTH(16)) u6 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load), .D(d16),
    .UP(up), .STEP(step_w), .Q(q6), .TC_MAX(obs_tmax[6]), .TC_MIN(obs_tmin[6]), .WRAP(obs_wrap[6]));
  v_counter_updown_param #(.WIDTH(16), .SATURATE(1)) u7 (.C(clk), .CLR(clr), .CE(ce), .LOAD(load),
    .D(d16), .UP(up), .STEP(step_w), .Q(q7), .TC_MAX(obs_tmax[7]), .TC_MIN(obs_tmin[7]),
    .WRAP(obs_wrap[7]));

  assign obs_q[0] = int'(q0);
  assign obs_q[1] = int'(q1);
  assign obs_q[2] = int'(q2);
  assign obs_q[3] = int'(q3);
  assign obs_q[4] = int'(q4);
  assign obs_q[5] = int'(q5);
  assign obs_q[6] = int'(q6);
  assign obs_q[7] = int'(q7);

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sext(input int v, input int w);
    int m;
    m = v & ((1 << w) - 1);
    if (((m >> (w - 1)) & 1) != 0) m -= (1 << w);
    return m;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NI; i++) begin
      mq[i] = 0;
      mw[i] = 0;
    end
  endfunction

  // Behaviour at one rising edge, from the rules: clear, enable, load-with-clamp, modular count.
  function automatic void model_advance();
    int st, nxt, dv, rng;
    for (int i = 0; i < NI; i++) begin
      rng = CMAX[i] - CMIN[i] + 1;
      if (clr) begin
        mq[i] = 0;
        mw[i] = 0;
      end else if (!ce) begin
        mw[i] = 0;
      end else if (load) begin
        dv = sext(int'(d16), CW[i]);
        mq[i] = (dv > CMAX[i]) ? CMAX[i] : (dv < CMIN[i]) ? CMIN[i] : dv;
        mw[i] = 0;
      end else begin
        st  = USE_N[i] != 0 ? int'(step_n) : int'(step_w);
        nxt = up ? mq[i] + st : mq[i] - st;
        if (nxt > CMAX[i] || nxt < CMIN[i]) begin
          mw[i] = 1;
          if (CSAT[i] != 0) mq[i] = (nxt > CMAX[i]) ? CMAX[i] : CMIN[i];
          else mq[i] = CMIN[i] + ((((nxt - CMIN[i]) % rng) + rng) % rng);
        end else begin
          mq[i] = nxt;
          mw[i] = 0;
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("q[%0d]", i), obs_q[i], mq[i]);
      chk($sformatf("tc_max[%0d]", i), int'(obs_tmax[i]), int'(mq[i] == CMAX[i]));
      chk($sformatf("tc_min[%0d]", i), int'(obs_tmin[i]), int'(mq[i] == CMIN[i]));
      chk($sformatf("wrap[%0d]", i), int'(obs_wrap[i]), mw[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_advance();
    compare_all();
  endtask

  initial begin
    clr = 1'b1; ce = 1'b0; load = 1'b0; up = 1'b0; d16 = '0; step_w = '0;
    model_clear();
    tick();
    tick();
    chk("rst_q0", obs_q[0], 0);
    chk("rst_wrap0", int'(obs_wrap[0]), 0);
    chk("rst_tcmax0", int'(obs_tmax[0]), 0);
    clr = 1'b0;

    // Wrap-mode count up by one through the 7 -> -8 boundary.
    ce = 1'b1; up = 1'b1; step_w = 4'd1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("up1_q0", obs_q[0], ((k + 8) % 16) - 8);
      chk("up1_wrap0", int'(obs_wrap[0]), int'(k == 8));
      chk("up1_tcmax0", int'(obs_tmax[0]), int'(((k + 8) % 16) - 8 == 7));
    end

    // Load -6, then count down by 3: -9 wraps to 7, then 4.
    load = 1'b1; d16 = 16'hFFFA;
    tick();
    chk("ld_q0", obs_q[0], -6);
    load = 1'b0; up = 1'b0; step_w = 4'd3;
    tick();
    chk("dn3_q0", obs_q[0], 7);
    chk("dn3_wrap0", int'(obs_wrap[0]), 1);
    tick();
    chk("dn3b_q0", obs_q[0], 4);
    chk("dn3b_wrap0", int'(obs_wrap[0]), 0);

    // Saturating [-3,5] counter stepping up by 2 from 0.
    load = 1'b1; d16 = 16'd0;
    tick();
    load = 1'b0; up = 1'b1; step_w = 4'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat_q1", obs_q[1], (k < 3) ? 2 * k : 5);
      chk("sat_wrap1", int'(obs_wrap[1]), int'(k >= 3));
      chk("sat_tcmax1", int'(obs_tmax[1]), int'(k >= 3));
    end

    // Enable gates load; load clamps; zero step holds.
    ce = 1'b0; load = 1'b1; d16 = 16'd3;
    tick();
    chk("ce0_q1", obs_q[1], 5);
    chk("ce0_wrap1", int'(obs_wrap[1]), 0);
    ce = 1'b1; d16 = 16'd9;
    tick();
    chk("ldclamp_q1", obs_q[1], 5);
    chk("ldclamp_wrap1", int'(obs_wrap[1]), 0);
    load = 1'b0; step_w = 4'd0;
    tick();
    chk("step0_q1", obs_q[1], 5);
    chk("step0_wrap1", int'(obs_wrap[1]), 0);

    // Async clear between edges while Q=6.
    load = 1'b1; d16 = 16'd6;
    tick();
    chk("pre_clr_q0", obs_q[0], 6);
    clr = 1'b1;
    #1;
    model_clear();
    chk("aclr_q0", obs_q[0], 0);
    chk("aclr_wrap0", int'(obs_wrap[0]), 0);
    compare_all();
    #1;
    clr = 1'b0; load = 1'b0; up = 1'b1; step_w = 4'd5;
    tick();
    chk("post_clr_q0", obs_q[0], 5);

    // Randomised traffic across all configurations.
    for (int n = 0; n < 10000; n++) begin
      clr    = ($urandom_range(0, 299) == 0);
      ce     = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 15) == 0);
      up     = 1'($urandom_range(0, 1));
      step_w = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       d16 = 16'($urandom);
        1:       d16 = 16'(32767 - int'($urandom_range(0, 20)));
        2:       d16 = 16'(-32768 + int'($urandom_range(0, 20)));
        default: d16 = 16'(int'($urandom_range(0, 20)) - 10);
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v_counter_updown_param.md
Name: v_counter_updown_param

Overview:
Parametrised signed up/down counter with asynchronous clear, synchronous load, clock enable, saturate-or-wrap mode and terminal-count flags. Next-generation general counter for the HDL coding-technique library; replaces fixed 4-bit signed up-counters. Usable as event counter, bounded accumulator index or timeout timer.

Parameters:
WIDTH, 8, counter width in bits (>=2); value is two's-complement signed
SATURATE, 0, 0 = wrap at bounds, 1 = clamp at MAX_VAL/MIN_VAL
MAX_VAL, 2**(WIDTH-1)-1, upper bound (signed); must satisfy MIN_VAL < MAX_VAL
MIN_VAL, -(2**(WIDTH-1)), lower bound (signed)
STEP_W, 4, width of unsigned step magnitude input

Ports:
C  input  1  clock, rising edge
CLR  input  1  reset CLR, asynchronous, active-high; clears counter and all flags
CE  input  1  clock enable; when low, counter and flags hold
LOAD  input  1  synchronous load of D
D  input  WIDTH  signed load value
UP  input  1  direction: 1 = count up, 0 = count down
STEP  input  STEP_W  unsigned step magnitude; 0 = hold value
Q  output  WIDTH  signed counter value, registered
TC_MAX  output  1  registered; high while Q == MAX_VAL
TC_MIN  output  1  registered; high while Q == MIN_VAL
WRAP  output  1  registered one-cycle pulse: last update crossed a bound (wrapped or clamped)

Behaviour:
- Reset: CLR high -> Q = 0 immediately (async), TC_MAX = (MAX_VAL==0), TC_MIN = (MIN_VAL==0), WRAP = 0. Release CLR synchronously with C at system level. CLR overrides all other inputs.
- Priority on a rising edge with CLR low: CE=0 -> hold everything, WRAP forced 0 -> else LOAD=1 -> Q <= clamp(D) to [MIN_VAL, MAX_VAL], WRAP <= 0 -> else count.
- Count: compute nxt = Q ± STEP in WIDTH+STEP_W+1 bit signed arithmetic (no intermediate overflow).
  - Up, nxt > MAX_VAL: wrap -> Q <= MIN_VAL + (nxt - MAX_VAL - 1), result reduced modulo range (MAX_VAL-MIN_VAL+1); saturate -> Q <= MAX_VAL. WRAP <= 1.
  - Down, nxt < MIN_VAL: wrap -> Q <= MAX_VAL - (MIN_VAL - nxt - 1), also modulo range; saturate -> Q <= MIN_VAL. WRAP <= 1.
  - Otherwise Q <= nxt, WRAP <= 0.
  - Saturate mode already at bound and pushing outward: Q holds, WRAP <= 1 every such cycle.
- Modulo reduction: STEP may exceed range only when the range is smaller than 2**STEP_W. Implement the reduction as a single conditional subtract/add when STEP <= range. STEP > range is unsupported; the implementation must assert on it in simulation.
- TC_MAX/TC_MIN are registered from the next Q value, so they align with Q in the same cycle (zero latency relative to Q).
- Latency: one clock from input to Q/flags. No combinational path from inputs to outputs.
- STEP=0 with CE=1: Q holds, WRAP=0.
- CLR asserted mid-count: Q = 0 within the same delta. The first edge after release counts from 0.

Decomposition:
- Package v_counter_pkg holds the mode constants (MODE_WRAP=0, MODE_SAT=1) and a function bound_adjust(nxt, min, max, sat), used by future counters.
- Sub-module v_counter_bound: combinational next-value/bound-detect logic (inputs Q, UP, STEP; outputs next_q, crossed). The top level holds only the registers.

Test Plan:
- WIDTH=4, defaults, wrap, UP=1, STEP=1, CE=1 for 20 cycles from reset -> Q 0..7, then -8 (WRAP pulse at the 7->-8 step), -7...; TC_MAX high exactly while Q=7.
- Wrap, UP=0, STEP=3, from Q=-6 (via LOAD) -> next Q=7 (-9 wraps), WRAP=1 for one cycle, then Q=4 with WRAP=0.
- SATURATE=1, MAX_VAL=5, MIN_VAL=-3, UP=1, STEP=2 from 0 -> Q 2, 4, 5, 5, 5; WRAP=1 on the 4->5 cycle and every following clamped cycle; TC_MAX=1 from the first Q=5.
- Priority: CE=0 with LOAD=1, D=3 -> Q unchanged. CE=1, LOAD=1, D=9 (MAX_VAL=5, saturate) -> Q=5. CE=1, LOAD=0, STEP=0 -> Q holds.
- Async CLR pulsed between clock edges while Q=6 -> Q=0 before the next edge, WRAP=0. The first edge after release gives Q=STEP.
- Randomised: 10k cycles of UP/STEP/LOAD/CE checked against a reference model for WIDTH=3, 8, 16 in both modes.
